alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Execute stage that consumes the 4-bit ALU control code and performs the operation on two XLEN operands.
//  Sits directly downstream of ALU control, taking its control_out on alu_ctrl.
//  Logical and arithmetic ops complete in 1 cycle.
//  Shifts use a 1-bit-per-cycle serial shifter to save area, so the block has a valid/ready handshake on both sides.
// PARAMETERS
//  XLEN     32               operand/result width; must be a power of 2, >= 8
//  SHAMT_W  $clog2(XLEN)     shift-amount width; the shift amount is op_b[SHAMT_W-1:0]
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        op_a/op_b/alu_ctrl are valid
//  in_ready   out  1        block can accept an operation (high only in IDLE)
//  alu_ctrl   in   4        op code: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU,
//                           0100 XOR, 0101 SRL, 1001 SRA, 0110 OR, 0111 AND
//  op_a       in   XLEN     operand A
//  op_b       in   XLEN     operand B
//  out_valid  out  1        result/zero/illegal are valid (high only in DONE)
//  out_ready  in   1        consumer accepts the result
//  result     out  XLEN     operation result
//  zero       out  1        result == 0
//  illegal    out  1        alu_ctrl was not one of the 10 listed codes
// BEHAVIOUR
//  Reset
//   - rst_n low at a rising edge: state=IDLE, result=0, zero=0, illegal=0, out_valid=0, shift counter=0.
//   - Applies mid-operation too: an in-flight op is discarded with no output, and in_valid is ignored while rst_n is low.
//  FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE), out_valid = (state==DONE).
//   - IDLE, in_valid=1, non-shift code: compute at this edge, go to DONE. Latency 1 cycle.
//   - IDLE, in_valid=1, shift code (SLL/SRL/SRA), n=op_b[SHAMT_W-1:0]:
//     - n=0: result=op_a, go to DONE.
//     - n>0: load work reg=op_a, cnt=n, go to SHIFT.
//   - SHIFT: each edge shifts the work reg by 1 (SLL fills 0; SRL fills 0; SRA fills the sign bit) and decrements cnt.
//     When cnt reaches 1 at an edge, the final shift happens and the state goes to DONE. Total latency is n+1 cycles.
//   - DONE: result/zero/illegal held stable while out_ready=0. out_ready=1: go to IDLE at the edge.
//     No new op is accepted in that same cycle, so maximum throughput is 1 op per 2 cycles.
//   - IDLE, in_valid=0: stay in IDLE; outputs keep their last values.
//  Arithmetic
//   - ADD/SUB are modulo 2^XLEN; no carry or overflow output.
//   - SLT: signed compare, result = {XLEN-1 zeros, a<b}. SLTU: the same, unsigned.
//   - XOR/OR/AND are bitwise. Bits of op_b above SHAMT_W are ignored for shifts.
//  Illegal code: result=0, zero=1, illegal=1, latency 1; handshake unchanged.
//  zero and illegal are registered alongside result and update only on entry to DONE.
//  Inputs are sampled only on the accept edge; changes in SHIFT/DONE have no effect.
// TESTING
//  1. Reset released, IDLE; ADD a=5, b=7 -> out_valid 1 cycle after accept; result=12, zero=0.
//  2. SUB a=3, b=3 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
//  3. SRA a=0x80000000, b=4 -> in_ready low 5 cycles; out_valid at cycle 5; result=0xF8000000.
//     SRL with b=0x24 (n=4) -> 0x08000000. SLL with b=0 -> result=a in 1 cycle.
//  4. Backpressure: ADD 1+1, hold out_ready=0 for 3 cycles -> result=2 stable, in_ready=0.
//     Then out_ready=1 -> IDLE next edge; an in_valid pulse during DONE is not accepted.
//  5. Illegal alu_ctrl=1111, a=9, b=9 -> result=0, illegal=1, zero=1, latency 1.
//  6. SLL a=1, b=31; assert rst_n=0 on the 10th SHIFT cycle -> next edge out_valid=0, result=0, in_ready=1 after release.
//     No stale result is ever presented.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execute stage for the 4-bit ALU control code: single-cycle logic/arithmetic,
// serial 1-bit-per-cycle shifter, valid/ready handshake on input and output.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

  state_t               state;
  shkind_t              kind;
  shkind_t              kind_in;
  logic [XLEN-1:0]      work;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic [XLEN-1:0]      shifted;
  logic [XLEN:0]        exec_out;

  function automatic logic [XLEN-1:0] shift_one(input shkind_t k, input logic [XLEN-1:0] v);
    case (k)
      SH_LL:   return {v[XLEN-2:0], 1'b0};
      SH_RL:   return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  // Returns {illegal, result}; shift codes yield op_a, which is the zero-distance shift.
  function automatic logic [XLEN:0] exec_op(input logic [3:0] ctrl,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (ctrl)
      OP_ADD:                  return {1'b0, a + b};
      OP_SUB:                  return {1'b0, a - b};
      OP_SLT:                  return {1'b0, {(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU:                 return {1'b0, {(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:                  return {1'b0, a ^ b};
      OP_OR:                   return {1'b0, a | b};
      OP_AND:                  return {1'b0, a & b};
      OP_SLL, OP_SRL, OP_SRA:  return {1'b0, a};
      default:                 return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  always_comb begin
    shamt    = op_b[SHAMT_W-1:0];
    is_shift = 1'b0;
    kind_in  = SH_LL;
    case (alu_ctrl)
      OP_SLL: begin is_shift = 1'b1; kind_in = SH_LL; end
      OP_SRL: begin is_shift = 1'b1; kind_in = SH_RL; end
      OP_SRA: begin is_shift = 1'b1; kind_in = SH_RA; end
      default: ;
    endcase
    shifted  = shift_one(kind, work);
    exec_out = exec_op(alu_ctrl, op_a, op_b);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control and visible outputs: reset clears them and discards any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              illegal <= exec_out[XLEN];
              result  <= exec_out[XLEN-1:0];
              zero    <= (exec_out[XLEN-1:0] == '0);
              state   <= DONE;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result  <= shifted;
            zero    <= (shifted == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: only meaningful while in SHIFT, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      work <= op_a;
      kind <= kind_in;
    end else if (state == SHIFT) begin
      work <= shifted;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: hand-computed vectors checked with immediate assertions.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int compared;
  int mismatched;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after accept, wait (bounded) for out_valid and check.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ill, input int exp_lat);
    int lat;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    alu_ctrl = c;
    op_a     = b ^ 32'h5A5A_0000;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    alu_ctrl = 4'b0100;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0003;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
    chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_rel_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    alu_ctrl   = 4'b0000;
    op_a       = '0;
    op_b       = '0;
    repeat (3) tick();
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    run_op("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
    release_out("add");
    run_op("sub", 4'b1000, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1);
    release_out("sub");
    run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    release_out("slt");
    run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    release_out("sltu");
    run_op("xor", 4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1'b0, 1);
    release_out("xor");
    run_op("or", 4'b0110, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 1'b0, 1);
    release_out("or");
    run_op("and", 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    release_out("and");

    run_op("sra4", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5);
    release_out("sra4");
    run_op("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 5);
    release_out("srl4");
    run_op("sll0", 4'b0001, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
    release_out("sll0");
    run_op("sra31", 4'b1001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    release_out("sra31");
    run_op("sll_out", 4'b0001, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b0, 1'b0, 2);
    release_out("sll_out");

    // Backpressure: result held while out_ready is low; pulse during DONE is ignored.
    run_op("bp", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_result", result, 32'd2);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0000;
    op_a      = 32'd5;
    op_b      = 32'd5;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_noaccept_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_noaccept_result", result, 32'd2);

    run_op("illegal", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1);
    release_out("illegal");
    run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    release_out("add_wrap");

    // Reset in the middle of a long shift.
    alu_ctrl = 4'b0001;
    op_a     = 32'd1;
    op_b     = 32'd31;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mid_shift_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_shift_ready", {31'b0, in_ready}, 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_ctrl = 4'b0000;
    op_a     = 32'd2;
    op_b     = 32'd2;
    tick();
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_zero", {31'b0, zero}, 32'd0);
    chk("rst_mid_illegal", {31'b0, illegal}, 32'd0);
    tick();
    chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("rst_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_rel_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_rel_result", result, 32'd0);

    run_op("post_rst", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
    release_out("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
